// File: rtl/i2c_cmd_sequencer.sv
// Replays a small table of 32-bit I2C master commands: write each to CMD,
// poll status until not busy, record errors, then wait an interval and repeat.
module i2c_cmd_sequencer #(
  parameter int NCMDS   = 4,
  parameter int TMRBITS = 24,
  parameter int SETTLE  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [3:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_m_cyc,
  output logic        o_m_stb,
  output logic        o_m_we,
  output logic [5:0]  o_m_addr,
  output logic [31:0] o_m_data,
  output logic [3:0]  o_m_sel,
  input  logic        i_m_ack,
  input  logic        i_m_stall,
  input  logic        i_m_err,
  input  logic [31:0] i_m_data,
  output logic        o_int
);
  localparam int IW = (NCMDS > 1) ? $clog2(NCMDS) : 1;
  localparam int SW = $clog2(SETTLE + 1) + 1;
  localparam logic [3:0] NC4 = 4'(NCMDS);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_POLL, ST_NEXT, ST_WAIT} state_t;
  state_t state, nxt;

  logic               enable, stop_on_err, halted, last_err;
  logic [TMRBITS-1:0] interval, tmr;
  logic [SW-1:0]      scnt;
  logic [2:0]         idx;
  logic [IW-1:0]      idx_i;
  logic [7:0]         pass_count;
  logic [NCMDS-1:0]   err_flags;
  logic [31:0]        tbl [NCMDS];
  logic [31:0]        rd;
  logic               wb_wr, ack_ev, busy, rec_err, last, halt, start;
  logic               unused_bits;

  assign o_wb_stall  = 1'b0;
  assign o_m_addr    = '0;
  assign o_m_sel     = 4'hf;
  assign idx_i       = idx[IW-1:0];
  assign wb_wr       = i_wb_cyc & i_wb_stb & i_wb_we;
  assign ack_ev      = o_m_cyc & (i_m_ack | i_m_err);
  assign busy        = i_m_data[31] & ~i_m_err;
  assign rec_err     = i_m_err | i_m_data[30];
  assign last        = (idx == 3'(NCMDS - 1));
  assign halt        = last_err & stop_on_err;
  // A new master cycle opens only from ISSUE/POLL when no cycle is in flight.
  assign start       = (state == ST_ISSUE || state == ST_POLL) && !o_m_cyc && enable;
  assign unused_bits = ^i_m_data[29:0];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (enable) nxt = ST_ISSUE;
      ST_ISSUE:
        if (ack_ev)                    nxt = i_m_err ? ST_NEXT : (enable ? ST_SETTLE : ST_IDLE);
        else if (!o_m_cyc && !enable)  nxt = ST_IDLE;
      ST_SETTLE:
        if (!enable)                   nxt = ST_IDLE;
        else if (scnt == '0)           nxt = ST_POLL;
      ST_POLL:
        if (ack_ev) begin
          if (!busy)                   nxt = ST_NEXT;
          else if (!enable)            nxt = ST_IDLE;
        end else if (!o_m_cyc && !enable) nxt = ST_IDLE;
      ST_NEXT:
        if (halt || !enable)           nxt = ST_IDLE;
        else if (!last)                nxt = ST_ISSUE;
        else                           nxt = ST_WAIT;
      ST_WAIT:
        if (!enable)                   nxt = ST_IDLE;
        else if (tmr <= TMRBITS'(1))   nxt = ST_ISSUE;
      default:                         nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd = '0;
    case (i_wb_addr)
      4'd0: begin
        rd[31]            = enable;
        rd[30]            = stop_on_err;
        rd[TMRBITS-1:0]   = interval;
      end
      4'd1: begin
        rd[31]            = (state != ST_IDLE);
        rd[30]            = halted;
        rd[26:24]         = idx;
        rd[23:16]         = pass_count;
        rd[NCMDS-1:0]     = err_flags;
      end
      default: rd = '0;
    endcase
  end

  // Table has no reset; writes land whenever, and are picked up on next issue.
  always_ff @(posedge i_clk)
    if (wb_wr && i_wb_addr[3] && ({1'b0, i_wb_addr[2:0]} < NC4))
      tbl[i_wb_addr[IW-1:0]] <= i_wb_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack    <= 1'b0;
      o_wb_data   <= '0;
      o_m_cyc     <= 1'b0;
      o_m_stb     <= 1'b0;
      o_m_we      <= 1'b0;
      o_m_data    <= '0;
      o_int       <= 1'b0;
      enable      <= 1'b0;
      stop_on_err <= 1'b0;
      interval    <= '0;
      halted      <= 1'b0;
      last_err    <= 1'b0;
      tmr         <= '0;
      scnt        <= '0;
      idx         <= '0;
      pass_count  <= '0;
      err_flags   <= '0;
    end else begin
      o_wb_ack <= i_wb_stb;
      o_int    <= 1'b0;
      if (i_wb_stb) o_wb_data <= rd;

      if (ack_ev) begin
        o_m_cyc <= 1'b0;
        o_m_stb <= 1'b0;
        o_m_we  <= 1'b0;
      end else if (start) begin
        o_m_cyc  <= 1'b1;
        o_m_stb  <= 1'b1;
        o_m_we   <= (state == ST_ISSUE);
        o_m_data <= (state == ST_ISSUE) ? tbl[idx_i] : '0;
      end else if (o_m_stb && !i_m_stall) begin
        o_m_stb  <= 1'b0;
      end

      case (state)
        ST_IDLE: if (enable) idx <= '0;
        ST_ISSUE: if (ack_ev) begin
          scnt <= SW'(SETTLE - 1);
          if (i_m_err) begin
            err_flags[idx_i] <= 1'b1;
            last_err         <= 1'b1;
          end
        end
        ST_SETTLE: if (scnt != '0) scnt <= scnt - SW'(1);
        ST_POLL: if (ack_ev && !busy) begin
          err_flags[idx_i] <= rec_err;
          last_err         <= rec_err;
        end
        ST_NEXT:
          if (halt) begin
            halted <= 1'b1;
            enable <= 1'b0;
          end else if (enable) begin
            if (!last) idx <= idx + 3'd1;
            else begin
              idx        <= '0;
              pass_count <= pass_count + 8'd1;
              o_int      <= 1'b1;
              tmr        <= interval;
            end
          end
        ST_WAIT: if (tmr != '0) tmr <= tmr - TMRBITS'(1);
        default: ;
      endcase

      // Bus writes come last so software wins a same-clock collision.
      if (wb_wr) begin
        if (i_wb_addr == 4'd0) begin
          enable      <= i_wb_data[31];
          stop_on_err <= i_wb_data[30];
          interval    <= i_wb_data[TMRBITS-1:0];
        end else if (i_wb_addr == 4'd1) begin
          err_flags <= '0;
          halted    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a small behavioural I2C-master target.
module tb_i2c_cmd_sequencer;
  localparam int NCMDS = 2;
  localparam logic [31:0] CMD0 = 32'h00A0_1004;
  localparam logic [31:0] CMD1 = 32'h00A1_1008;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [3:0]  wb_addr = 0;
  logic [31:0] wb_wdat = 0;
  logic        wb_ack, wb_stall;
  logic [31:0] wb_rdat;
  logic        m_cyc, m_stb, m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_wdat;
  logic [3:0]  m_sel;
  logic        m_ack = 0, m_err = 0, m_stall;
  logic [31:0] m_rdat = 0;
  logic        irq;

  int compared = 0, mismatched = 0;

  // target configuration (driven by tests) and state (driven by the model)
  int stall_req = 0, busy_req = 0, ack_dly = 0;
  logic err_en = 0;
  logic [31:0] err_cmd = 0;
  int stall_cnt = 0, busy_cnt = 0, dly_cnt = 0, n_wr = 0, n_rd = 0;
  logic pend = 0, pend_we = 0;
  logic [31:0] last_wr = 0;
  logic [31:0] wr_log [$];

  i2c_cmd_sequencer #(.NCMDS(NCMDS), .TMRBITS(24), .SETTLE(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
    .i_wb_data(wb_wdat), .o_wb_ack(wb_ack), .o_wb_stall(wb_stall), .o_wb_data(wb_rdat),
    .o_m_cyc(m_cyc), .o_m_stb(m_stb), .o_m_we(m_we), .o_m_addr(m_addr),
    .o_m_data(m_wdat), .o_m_sel(m_sel), .i_m_ack(m_ack), .i_m_stall(m_stall),
    .i_m_err(m_err), .i_m_data(m_rdat), .o_int(irq)
  );

  assign m_stall = m_cyc && m_stb && (stall_cnt < stall_req);

  // Target: accept when stb && !stall, ack ack_dly+1 clocks later.
  always @(posedge clk) begin
    m_ack  <= 1'b0;
    m_rdat <= '0;
    if (!rst_n) begin
      pend      <= 1'b0;
      stall_cnt <= 0;
    end else begin
      if (m_cyc && m_stb && m_stall) stall_cnt <= stall_cnt + 1;
      else if (!m_stb)               stall_cnt <= 0;
      if (m_cyc && m_stb && !m_stall && !pend) begin
        pend    <= 1'b1;
        pend_we <= m_we;
        dly_cnt <= ack_dly;
        if (m_we) begin
          n_wr     <= n_wr + 1;
          last_wr  <= m_wdat;
          busy_cnt <= 0;
          wr_log.push_back(m_wdat);
        end else n_rd <= n_rd + 1;
      end
      if (pend) begin
        if (dly_cnt > 0) dly_cnt <= dly_cnt - 1;
        else begin
          m_ack <= 1'b1;
          pend  <= 1'b0;
          if (!pend_we) begin
            if (busy_cnt < busy_req) begin
              m_rdat   <= 32'h8000_0000;
              busy_cnt <= busy_cnt + 1;
            end else m_rdat <= {1'b0, err_en && (last_wr == err_cmd), 30'd0};
          end
        end
      end
    end
  end

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = a; wb_wdat = d;
    @(negedge clk); wb_cyc = 0; wb_stb = 0; wb_we = 0;
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk); wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a;
    @(negedge clk); wb_cyc = 0; wb_stb = 0; d = wb_rdat; ack = wb_ack;
  endtask

  task automatic apply_reset;
    @(negedge clk); rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset;
    logic [31:0] d; logic a;
    #2 rst_n = 0; #1;
    compared++; if (m_cyc !== 1'b0) begin mismatched++; $display("FAIL rst_cyc got=%b exp=0", m_cyc); end
    compared++; if (m_stb !== 1'b0) begin mismatched++; $display("FAIL rst_stb got=%b exp=0", m_stb); end
    compared++; if (irq !== 1'b0) begin mismatched++; $display("FAIL rst_int got=%b exp=0", irq); end
    compared++; if (m_sel !== 4'hf) begin mismatched++; $display("FAIL rst_sel got=%h exp=f", m_sel); end
    compared++; if (m_wdat !== 32'h0) begin mismatched++; $display("FAIL rst_mdata got=%h exp=0", m_wdat); end
    compared++; if (wb_rdat !== 32'h0) begin mismatched++; $display("FAIL rst_wbdata got=%h exp=0", wb_rdat); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    wb_read(4'd0, d, a);
    compared++; if (a !== 1'b1) begin mismatched++; $display("FAIL wb_ack got=%b exp=1", a); end
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL rst_ctrl got=%h exp=0", d); end
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL rst_status got=%h exp=0", d); end
    compared++; if (wb_stall !== 1'b0) begin mismatched++; $display("FAIL wb_stall got=%b exp=0", wb_stall); end
    wb_write(4'd8, CMD0);
    wb_write(4'd9, CMD1);
  endtask

  task automatic test_pass;
    int base, r0, t; logic [31:0] d; logic a;
    apply_reset;
    base = wr_log.size(); r0 = n_rd;
    wb_write(4'd0, 32'h8000_0064);
    t = 0; while (!irq && t < 400) begin @(negedge clk); t++; end
    compared++; if (t >= 400) begin mismatched++; $display("FAIL pass_timeout got=%0d exp<400", t); end
    compared++; if (wr_log.size() - base !== 2) begin mismatched++; $display("FAIL pass_nwr got=%0d exp=2", wr_log.size() - base); end
    compared++; if (wr_log[base] !== CMD0) begin mismatched++; $display("FAIL pass_cmd0 got=%h exp=%h", wr_log[base], CMD0); end
    compared++; if (wr_log[base+1] !== CMD1) begin mismatched++; $display("FAIL pass_cmd1 got=%h exp=%h", wr_log[base+1], CMD1); end
    compared++; if (n_rd - r0 !== 2) begin mismatched++; $display("FAIL pass_nrd got=%0d exp=2", n_rd - r0); end
    // 100 WAIT clocks plus the ISSUE clock that opens the next cycle
    t = 0; while (!m_cyc && t < 300) begin @(negedge clk); t++; end
    compared++; if (t !== 101) begin mismatched++; $display("FAIL pass_gap got=%0d exp=101", t); end
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h8001_0000) begin mismatched++; $display("FAIL pass_status got=%h exp=80010000", d); end
    wb_write(4'd0, 32'h0);
    repeat (20) @(negedge clk);
    wb_read(4'd1, d, a);
    compared++; if (d[31] !== 1'b0) begin mismatched++; $display("FAIL pass_stop got=%b exp=0", d[31]); end
  endtask

  task automatic test_busy;
    int base, r1, t, low, runs1;
    apply_reset;
    busy_req = 3; base = wr_log.size();
    wb_write(4'd0, 32'h8000_03E8);
    t = 0; while (wr_log.size() - base < 1 && t < 100) begin @(negedge clk); t++; end
    r1 = n_rd; low = 0; runs1 = 0;
    t = 0;
    while (wr_log.size() - base < 2 && t < 400) begin
      @(negedge clk); t++;
      if (!m_cyc) low++;
      else begin if (low == 1) runs1++; low = 0; end
    end
    compared++; if (t >= 400) begin mismatched++; $display("FAIL busy_timeout got=%0d exp<400", t); end
    compared++; if (n_rd - r1 !== 4) begin mismatched++; $display("FAIL busy_polls got=%0d exp=4", n_rd - r1); end
    compared++; if (runs1 !== 3) begin mismatched++; $display("FAIL busy_gaps got=%0d exp=3", runs1); end
    busy_req = 0;
    wb_write(4'd0, 32'h0);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_err_halt;
    int base, t; logic [31:0] d; logic a;
    apply_reset;
    err_en = 1; err_cmd = CMD1; base = wr_log.size();
    wb_write(4'd0, 32'hC000_0005);
    t = 0; while (wr_log.size() - base < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (60) @(negedge clk);
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h4100_0002) begin mismatched++; $display("FAIL halt_status got=%h exp=41000002", d); end
    wb_read(4'd0, d, a);
    compared++; if (d !== 32'h4000_0005) begin mismatched++; $display("FAIL halt_ctrl got=%h exp=40000005", d); end
    compared++; if (wr_log.size() - base !== 2) begin mismatched++; $display("FAIL halt_nwr got=%0d exp=2", wr_log.size() - base); end
    compared++; if (m_cyc !== 1'b0) begin mismatched++; $display("FAIL halt_cyc got=%b exp=0", m_cyc); end
    wb_write(4'd1, 32'h0);
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h0100_0000) begin mismatched++; $display("FAIL halt_clear got=%h exp=01000000", d); end
    err_en = 0;
  endtask

  task automatic test_stall;
    int base, t, stalled, acc;
    apply_reset;
    stall_req = 5; base = wr_log.size();
    wb_write(4'd0, 32'h8000_03E8);
    t = 0; while (!m_stb && t < 20) begin @(negedge clk); t++; end
    compared++; if (!(m_we === 1'b1 && m_cyc === 1'b1 && m_wdat === CMD0)) begin
      mismatched++; $display("FAIL stall_req got=%b%b/%h exp=11/%h", m_cyc, m_we, m_wdat, CMD0); end
    stalled = 0; acc = 0; t = 0;
    while (m_stb && t < 20) begin
      if (m_stall) stalled++; else acc++;
      @(negedge clk); t++;
    end
    stall_req = 0;
    compared++; if (stalled !== 5) begin mismatched++; $display("FAIL stall_clocks got=%0d exp=5", stalled); end
    compared++; if (acc !== 1) begin mismatched++; $display("FAIL stall_accept got=%0d exp=1", acc); end
    compared++; if (wr_log.size() - base !== 1) begin mismatched++; $display("FAIL stall_nwr got=%0d exp=1", wr_log.size() - base); end
    wb_write(4'd0, 32'h0);
    repeat (20) @(negedge clk);
  endtask

  task automatic test_disable_poll;
    int base, r0, t; logic [31:0] d; logic a;
    apply_reset;
    ack_dly = 6; base = wr_log.size(); r0 = n_rd;
    wb_write(4'd0, 32'h8000_03E8);
    t = 0; while (!(m_cyc && !m_we) && t < 100) begin @(negedge clk); t++; end
    wb_write(4'd0, 32'h0);
    compared++; if (m_cyc !== 1'b1) begin mismatched++; $display("FAIL dis_keep_cyc got=%b exp=1", m_cyc); end
    t = 0; while (m_cyc && t < 20) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL dis_status got=%h exp=0", d); end
    compared++; if (n_rd - r0 !== 1) begin mismatched++; $display("FAIL dis_nrd got=%0d exp=1", n_rd - r0); end
    compared++; if (wr_log.size() - base !== 1) begin mismatched++; $display("FAIL dis_nwr got=%0d exp=1", wr_log.size() - base); end
    // reset while a CMD write is open
    wb_write(4'd0, 32'h8000_03E8);
    t = 0; while (!(m_cyc && m_we) && t < 100) begin @(negedge clk); t++; end
    rst_n = 0; #1;
    compared++; if (m_cyc !== 1'b0) begin mismatched++; $display("FAIL rst_mid_cyc got=%b exp=0", m_cyc); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    ack_dly = 0;
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h0) begin mismatched++; $display("FAIL rst_mid_status got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back;
    int t, cnt; logic [31:0] d; logic a;
    apply_reset;
    wb_write(4'd0, 32'h8000_0000);
    t = 0; while (!irq && t < 400) begin @(negedge clk); t++; end
    // one WAIT clock, one ISSUE launch clock
    t = 0; while (!m_cyc && t < 50) begin @(negedge clk); t++; end
    compared++; if (t !== 2) begin mismatched++; $display("FAIL b2b_gap got=%0d exp=2", t); end
    cnt = 1; t = 0;
    while (cnt < 255 && t < 15000) begin @(negedge clk); t++; if (irq) cnt++; end
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h80FF_0000) begin mismatched++; $display("FAIL wrap_255 got=%h exp=80ff0000", d); end
    t = 0; while (!irq && t < 200) begin @(negedge clk); t++; end
    wb_read(4'd1, d, a);
    compared++; if (d !== 32'h8000_0000) begin mismatched++; $display("FAIL wrap_0 got=%h exp=80000000", d); end
    wb_write(4'd0, 32'h0);
  endtask

  initial begin
    test_reset;
    test_pass;
    test_busy;
    test_err_halt;
    test_stall;
    test_disable_poll;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
